riscv_wb_arbiter: RTL and testbench
===================================

Name: riscv_wb_arbiter

Overview:
Write-back arbiter in front of the architectural register file. It accepts write-back results from WB_REQUESTERS functional units (ALU, LSU, MUL/DIV, CSR) through valid/ready handshakes and holds each result in a one-entry buffer per requester. Each cycle it grants up to REGISTER_PORTS buffered results using rotating priority, and drives the register file write ports. The register file clears the lock bit of each written register.

Parameters:
WB_REQUESTERS, 4, number of write-back sources.
REGISTER_PORTS, riscv_pkg::REGISTER_PORTS (2), register file write ports driven per cycle.

Ports:
clock  input  1  clock.
reset  input  1  synchronous, active-high reset.
req_valid  input  [WB_REQUESTERS]  requester n presents a result.
req_ready  output  [WB_REQUESTERS]  requester n's buffer accepts a result this cycle.
req_reg  input  [WB_REQUESTERS][6]  destination register index.
req_data  input  [WB_REQUESTERS][32]  result data.
register_write_en  output  [REGISTER_PORTS]  register file write enable per port.
register_write  output  [REGISTER_PORTS][6]  register file write index per port.
register_write_data  output  [REGISTER_PORTS][32]  register file write data per port.
wb_busy  output  1  at least one buffer is occupied.
wb_err_range  output  1  one-cycle pulse: a result with index >= 32 was accepted and dropped.

Behaviour:
- Reset values: all buffers empty; rotating pointer = 0; req_ready = all ones; register_write_en = 0; register_write = 0; register_write_data = 0; wb_busy = 0; wb_err_range = 0.
- Reset is synchronous and can occur mid-operation. It clears all buffers; pending results are lost, and the issue logic must flush.
- Buffer n is one entry: {valid, reg[5:0], data[31:0]}.
- Handshake: req_ready[n] = !buf_valid[n] || granted[n] (same-cycle refill allowed). A transfer occurs when req_valid[n] && req_ready[n]. It writes buf[n] at the clock edge.
- Latency: a result accepted at edge t is eligible for grant in cycle t+1. With no contention, the register file updates at edge t+1.
- There is no combinational path from req_* to register_write_*. Outputs derive from buffers and the pointer only.
- Grant order: scan requesters ptr, ptr+1, …, wrapping mod WB_REQUESTERS. Grant valid buffers in scan order until REGISTER_PORTS grants are made.
- Port assignment: the k-th grant in scan order drives write port k. Unused ports have en = 0, index = 0, data = 0.
- Same-register conflict: if a buffer's reg equals the reg of an earlier grant in the same scan, it is skipped this cycle. It stays buffered, so two ports never write one index in one cycle.
- x0 (reg == 0): granted normally, written with data forced to 0. This clears the x0 lock bit.
- Out-of-range index (reg[5] == 1): a granted buffer is cleared without asserting a write port. wb_err_range pulses in that cycle. The entry consumes a grant slot.
- Pointer update: on any grant, ptr <= (index of last granted requester + 1) mod WB_REQUESTERS. If there is no grant, ptr is held.
- Fairness: any valid buffer is granted within ceil(WB_REQUESTERS / REGISTER_PORTS) cycles, absent same-register conflicts.
- wb_busy = OR of buf_valid (combinational from state).
- Width rules: index is 6 bits, data is 32 bits. The pointer width is $clog2(WB_REQUESTERS), with explicit wrap for non-power-of-2 counts.

Decomposition:
- riscv_pkg gains: WB_REQUESTERS constant; typedef wb_entry_t struct packed {logic valid; logic [5:0] rd; logic [31:0] data;}; requester index constants WB_ALU = 0, WB_LSU = 1, WB_MUL = 2, WB_CSR = 3.
- One sub-module: riscv_wb_rr_pick. It is combinational. Inputs: valid mask, reg indices, ptr. Outputs: grant mask, per-port requester select, next ptr. It contains the scan and the conflict skip, and is unit-testable alone.

Test Plan:
- Single result: ALU reg = 5, data = 0xDEADBEEF at t0 -> en[0] = 1, write = 5, data = 0xDEADBEEF in t1; en[1] = 0; ready[0] stays 1.
- Four results at once, ptr = 0, regs 1/2/3/4 -> t1 grants requesters 0 and 1, and ptr becomes 2. t2 grants requesters 2 and 3, and ptr becomes 0. ready[2] and ready[3] are 0 in t1.
- Same-register conflict: requesters 0 and 1 both target reg 7 (data 0x1, 0x2) -> t1 writes 0x1 only. t2 writes 0x2 on port 0. The final value is 0x2.
- x0 and out-of-range: LSU reg = 0, data = 0x55, and MUL reg = 40 -> port write index 0 with data 0. The MUL entry is cleared, wb_err_range = 1 for exactly one cycle, and no port carries index 40.
- Back-to-back streaming: ALU offers a new result every cycle for 10 cycles, other requesters idle -> req_ready[0] is held at 1 and one write per cycle, in order.
- Reset mid-operation: three buffers full, reset asserted for one cycle -> the next cycle has all en = 0, wb_busy = 0, req_ready all ones, and ptr = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the write-back path of the core.
package riscv_pkg;

  // Register file write ports available to write-back each cycle.
  localparam int REGISTER_PORTS = 2;

  // Number of functional units that produce write-back results.
  localparam int WB_REQUESTERS = 4;

  // Requester slots on the arbiter.
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MUL = 2;
  localparam int WB_CSR = 3;

  // One buffered write-back result. rd[5] set means the index is out of range.
  typedef struct packed {
    logic        valid;
    logic [5:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/riscv_wb_rr_pick.sv
// Rotating-priority picker: scans valid buffers starting at the pointer,
// skips entries whose destination collides with an earlier grant, and
// hands out up to P grants in scan order (k-th grant -> port k).
module riscv_wb_rr_pick #(
  parameter int N  = riscv_pkg::WB_REQUESTERS,
  parameter int P  = riscv_pkg::REGISTER_PORTS,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         i_valid,
  input  logic [N-1:0][5:0]    i_rd,
  input  logic [PW-1:0]        i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [P-1:0]         o_port_valid,
  output logic [P-1:0][PW-1:0] o_port_sel,
  output logic [PW-1:0]        o_next_ptr
);

  // Scan from the pointer with explicit wrap; all selects use loop constants.
  always_comb begin
    int         w_cnt;
    int         w_idx;
    logic       w_cand_valid;
    logic [5:0] w_cand_rd;
    logic       w_conflict;
    logic [5:0] w_taken_rd [P];

    o_grant      = '0;
    o_port_valid = '0;
    o_port_sel   = '0;
    o_next_ptr   = i_ptr;
    w_cnt        = 0;
    for (int k = 0; k < P; k++) begin
      w_taken_rd[k] = '0;
    end

    for (int s = 0; s < N; s++) begin
      w_idx = int'(i_ptr) + s;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end

      w_cand_valid = 1'b0;
      w_cand_rd    = '0;
      for (int i = 0; i < N; i++) begin
        if (i == w_idx) begin
          w_cand_valid = i_valid[i];
          w_cand_rd    = i_rd[i];
        end
      end

      // An entry targeting a register already granted this cycle waits.
      w_conflict = 1'b0;
      for (int k = 0; k < P; k++) begin
        if (k < w_cnt && w_taken_rd[k] == w_cand_rd) begin
          w_conflict = 1'b1;
        end
      end

      if (w_cand_valid && w_cnt < P && !w_conflict) begin
        for (int i = 0; i < N; i++) begin
          if (i == w_idx) begin
            o_grant[i] = 1'b1;
          end
        end
        for (int k = 0; k < P; k++) begin
          if (k == w_cnt) begin
            o_port_valid[k] = 1'b1;
            o_port_sel[k]   = PW'(w_idx);
            w_taken_rd[k]   = w_cand_rd;
          end
        end
        w_cnt      = w_cnt + 1;
        o_next_ptr = (w_idx == N - 1) ? '0 : PW'(w_idx + 1);
      end
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter: one-entry buffer per functional unit, rotating-priority
// grant onto the register file write ports. Port outputs come only from the
// buffers and the pointer, never combinationally from the request inputs.
module riscv_wb_arbiter #(
  parameter int WB_REQUESTERS  = riscv_pkg::WB_REQUESTERS,
  parameter int REGISTER_PORTS = riscv_pkg::REGISTER_PORTS
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [WB_REQUESTERS-1:0]             req_valid,
  output logic [WB_REQUESTERS-1:0]             req_ready,
  input  logic [WB_REQUESTERS-1:0][5:0]        req_reg,
  input  logic [WB_REQUESTERS-1:0][31:0]       req_data,
  output logic [REGISTER_PORTS-1:0]            register_write_en,
  output logic [REGISTER_PORTS-1:0][5:0]       register_write,
  output logic [REGISTER_PORTS-1:0][31:0]      register_write_data,
  output logic                                 wb_busy,
  output logic                                 wb_err_range
);

  import riscv_pkg::wb_entry_t;

  localparam int PW = (WB_REQUESTERS > 1) ? $clog2(WB_REQUESTERS) : 1;

  wb_entry_t r_buf [WB_REQUESTERS];
  logic [PW-1:0] r_ptr;

  logic [WB_REQUESTERS-1:0]            w_buf_valid;
  logic [WB_REQUESTERS-1:0][5:0]       w_buf_rd;
  logic [WB_REQUESTERS-1:0]            w_grant;
  logic [WB_REQUESTERS-1:0]            w_range_drop;
  logic [REGISTER_PORTS-1:0]           w_port_valid;
  logic [REGISTER_PORTS-1:0][PW-1:0]   w_port_sel;
  logic [PW-1:0]                       w_next_ptr;

  genvar gi;

  generate
    for (gi = 0; gi < WB_REQUESTERS; gi++) begin : g_req
      assign w_buf_valid[gi]  = r_buf[gi].valid;
      assign w_buf_rd[gi]     = r_buf[gi].rd;
      // A granted buffer drains this cycle, so it may be refilled at once.
      assign req_ready[gi]    = !r_buf[gi].valid || w_grant[gi];
      assign w_range_drop[gi] = w_grant[gi] && r_buf[gi].rd[5];
    end
  endgenerate

  riscv_wb_rr_pick #(
    .N  (WB_REQUESTERS),
    .P  (REGISTER_PORTS),
    .PW (PW)
  ) u_pick (
    .i_valid      (w_buf_valid),
    .i_rd         (w_buf_rd),
    .i_ptr        (r_ptr),
    .o_grant      (w_grant),
    .o_port_valid (w_port_valid),
    .o_port_sel   (w_port_sel),
    .o_next_ptr   (w_next_ptr)
  );

  generate
    for (gi = 0; gi < REGISTER_PORTS; gi++) begin : g_port
      wb_entry_t w_sel;
      logic      w_en;

      // Fetch the buffer chosen for this port.
      always_comb begin
        w_sel = r_buf[w_port_sel[gi]];
      end

      // Out-of-range entries occupy the slot but never reach the register file;
      // x0 writes go through with zero data so its lock bit clears.
      assign w_en                    = w_port_valid[gi] && w_sel.valid && !w_sel.rd[5];
      assign register_write_en[gi]   = w_en;
      assign register_write[gi]      = w_en ? w_sel.rd : 6'd0;
      assign register_write_data[gi] = (w_en && w_sel.rd != 6'd0) ? w_sel.data : 32'd0;
    end
  endgenerate

  assign wb_busy      = |w_buf_valid;
  assign wb_err_range = |w_range_drop;

  // Buffer fill/drain and pointer advance; reset discards pending results.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WB_REQUESTERS; i++) begin
        r_buf[i] <= '0;
      end
      r_ptr <= '0;
    end else begin
      for (int i = 0; i < WB_REQUESTERS; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          r_buf[i] <= '{valid: 1'b1, rd: req_reg[i], data: req_data[i]};
        end else if (w_grant[i]) begin
          r_buf[i].valid <= 1'b0;
        end
      end
      if (|w_grant) begin
        r_ptr <= w_next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_riscv_wb_arbiter;

  localparam int N = 4;
  localparam int P = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0][5:0]  req_reg;
  logic [N-1:0][31:0] req_data;
  logic [P-1:0]       register_write_en;
  logic [P-1:0][5:0]  register_write;
  logic [P-1:0][31:0] register_write_data;
  logic               wb_busy;
  logic               wb_err_range;

  riscv_wb_arbiter #(.WB_REQUESTERS(N), .REGISTER_PORTS(P)) dut (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_reg             (req_reg),
    .req_data            (req_data),
    .register_write_en   (register_write_en),
    .register_write      (register_write),
    .register_write_data (register_write_data),
    .wb_busy             (wb_busy),
    .wb_err_range        (wb_err_range)
  );

  // Unpacked views of the DUT ports for easy indexing.
  logic        tb_valid [N];
  logic [5:0]  tb_reg   [N];
  logic [31:0] tb_data  [N];
  logic        o_rdy    [N];
  logic        o_en     [P];
  logic [5:0]  o_wr     [P];
  logic [31:0] o_dat    [P];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign req_valid[gi] = tb_valid[gi];
      assign req_reg[gi]   = tb_reg[gi];
      assign req_data[gi]  = tb_data[gi];
      assign o_rdy[gi]     = req_ready[gi];
    end
    for (gi = 0; gi < P; gi++) begin : g_port
      assign o_en[gi]  = register_write_en[gi];
      assign o_wr[gi]  = register_write[gi];
      assign o_dat[gi] = register_write_data[gi];
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit          m_v  [N];
  int          m_rd [N];
  logic [31:0] m_d  [N];
  int          m_ptr;
  logic [31:0] dut_rf [32];

  // Expected outputs for the current cycle.
  bit          e_grant [N];
  bit          e_en    [P];
  int          e_wr    [P];
  logic [31:0] e_data  [P];
  bit          e_err;
  int          e_next;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Rotating scan from the spec rules: walk requesters from the pointer,
  // grant until the ports run out, skipping repeats of a granted register.
  task automatic predict();
    int taken[$];
    int cnt;
    int last;
    int i;
    bit dup;
    cnt = 0;
    last = -1;
    e_err = 0;
    for (int n = 0; n < N; n++) e_grant[n] = 0;
    for (int k = 0; k < P; k++) begin
      e_en[k] = 0; e_wr[k] = 0; e_data[k] = 0;
    end
    for (int s = 0; s < N; s++) begin
      i = (m_ptr + s) % N;
      if (m_v[i] && cnt < P) begin
        dup = 0;
        foreach (taken[t]) if (taken[t] == m_rd[i]) dup = 1;
        if (!dup) begin
          taken.push_back(m_rd[i]);
          e_grant[i] = 1;
          if (m_rd[i] < 32) begin
            e_en[cnt]   = 1;
            e_wr[cnt]   = m_rd[i];
            e_data[cnt] = (m_rd[i] == 0) ? 32'd0 : m_d[i];
          end else begin
            e_err = 1;
          end
          cnt++;
          last = i;
        end
      end
    end
    e_next = (cnt > 0) ? (last + 1) % N : m_ptr;
  endtask

  task automatic model_update();
    bit any;
    any = 0;
    if (reset) begin
      for (int n = 0; n < N; n++) m_v[n] = 0;
      m_ptr = 0;
    end else begin
      for (int n = 0; n < N; n++) begin
        if (e_grant[n]) any = 1;
        if (tb_valid[n] && (!m_v[n] || e_grant[n])) begin
          m_v[n] = 1; m_rd[n] = int'(tb_reg[n]); m_d[n] = tb_data[n];
        end else if (e_grant[n]) begin
          m_v[n] = 0;
        end
      end
      if (any) m_ptr = e_next;
    end
  endtask

  // Mid-cycle: compare every output against the model.
  task automatic half();
    bit busy;
    @(negedge clock);
    predict();
    busy = 0;
    for (int n = 0; n < N; n++) begin
      if (m_v[n]) busy = 1;
      chk($sformatf("ready%0d", n), 64'(o_rdy[n]), 64'(!m_v[n] || e_grant[n]));
    end
    for (int k = 0; k < P; k++) begin
      chk($sformatf("en%0d", k), 64'(o_en[k]), 64'(e_en[k]));
      chk($sformatf("wr%0d", k), 64'(o_wr[k]), 64'(e_wr[k]));
      chk($sformatf("data%0d", k), 64'(o_dat[k]), 64'(e_data[k]));
      if (o_en[k] === 1'b1 && o_wr[k] < 6'd32) dut_rf[o_wr[k][4:0]] = o_dat[k];
    end
    chk("busy", 64'(wb_busy), 64'(busy));
    chk("err_range", 64'(wb_err_range), 64'(e_err));
  endtask

  task automatic edge_step();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    for (int n = 0; n < N; n++) tb_valid[n] = 0;
  endtask

  task automatic drive(input int n, input int rd, input logic [31:0] d);
    tb_valid[n] = 1; tb_reg[n] = 6'(rd); tb_data[n] = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    half();
    edge_step();
    reset = 0;
  endtask

  initial begin
    for (int n = 0; n < N; n++) begin
      tb_valid[n] = 0; tb_reg[n] = 0; tb_data[n] = 0; m_v[n] = 0; m_rd[n] = 0; m_d[n] = 0;
    end
    for (int r = 0; r < 32; r++) dut_rf[r] = 0;
    m_ptr = 0;
    reset = 1;
    @(posedge clock); @(posedge clock); #1;
    reset = 0;

    // Reset state.
    half();
    chk("rst_en", 64'(register_write_en), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(4'hF));
    chk("rst_busy", 64'(wb_busy), 64'(0));
    chk("rst_err", 64'(wb_err_range), 64'(0));
    edge_step();

    // Single ALU result.
    drive(0, 5, 32'hDEADBEEF);
    half(); edge_step();
    idle();
    half();
    chk("single_en", 64'(register_write_en), 64'(2'b01));
    chk("single_wr", 64'(o_wr[0]), 64'(5));
    chk("single_data", 64'(o_dat[0]), 64'(32'hDEADBEEF));
    chk("single_ready0", 64'(o_rdy[0]), 64'(1));
    edge_step();

    // Four results at once from pointer 0.
    do_reset();
    for (int n = 0; n < N; n++) drive(n, n + 1, 32'h10 + n);
    half(); edge_step();
    idle();
    half();
    chk("four_t1_en", 64'(register_write_en), 64'(2'b11));
    chk("four_t1_wr0", 64'(o_wr[0]), 64'(1));
    chk("four_t1_wr1", 64'(o_wr[1]), 64'(2));
    chk("four_t1_ready", 64'(req_ready), 64'(4'b0011));
    edge_step();
    half();
    chk("four_t2_wr0", 64'(o_wr[0]), 64'(3));
    chk("four_t2_wr1", 64'(o_wr[1]), 64'(4));
    edge_step();

    // Same-register conflict.
    do_reset();
    drive(0, 7, 32'h1);
    drive(1, 7, 32'h2);
    half(); edge_step();
    idle();
    half();
    chk("conf_t1_en", 64'(register_write_en), 64'(2'b01));
    chk("conf_t1_data", 64'(o_dat[0]), 64'(1));
    edge_step();
    half();
    chk("conf_t2_en", 64'(register_write_en), 64'(2'b01));
    chk("conf_t2_data", 64'(o_dat[0]), 64'(2));
    edge_step();
    chk("conf_rf7", 64'(dut_rf[7]), 64'(2));

    // x0 write and out-of-range drop.
    do_reset();
    drive(1, 0, 32'h55);
    drive(2, 40, 32'h77);
    half(); edge_step();
    idle();
    half();
    chk("x0_en", 64'(register_write_en), 64'(2'b01));
    chk("x0_wr", 64'(o_wr[0]), 64'(0));
    chk("x0_data", 64'(o_dat[0]), 64'(0));
    chk("oor_err", 64'(wb_err_range), 64'(1));
    edge_step();
    half();
    chk("oor_err_clear", 64'(wb_err_range), 64'(0));
    chk("oor_busy", 64'(wb_busy), 64'(0));
    edge_step();

    // Back-to-back streaming on the ALU.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, i + 1, 32'(i * 3));
      half();
      chk("stream_ready", 64'(o_rdy[0]), 64'(1));
      if (i > 0) chk("stream_wr", 64'(o_wr[0]), 64'(i));
      edge_step();
    end
    idle();
    half();
    chk("stream_last", 64'(o_wr[0]), 64'(10));
    edge_step();

    // Reset with three buffers full.
    do_reset();
    drive(0, 11, 32'hA); drive(1, 12, 32'hB); drive(2, 13, 32'hC);
    half(); edge_step();
    idle();
    reset = 1;
    half(); edge_step();
    reset = 0;
    half();
    chk("mrst_en", 64'(register_write_en), 64'(0));
    chk("mrst_busy", 64'(wb_busy), 64'(0));
    chk("mrst_ready", 64'(req_ready), 64'(4'hF));
    edge_step();
    drive(1, 21, 32'h1); drive(2, 22, 32'h2); drive(3, 23, 32'h3);
    half(); edge_step();
    idle();
    half();
    chk("mrst_ptr_wr0", 64'(o_wr[0]), 64'(21));
    chk("mrst_ptr_wr1", 64'(o_wr[1]), 64'(22));
    edge_step();
    half(); edge_step();

    // Randomized traffic with conflicts, x0, out-of-range and rare resets.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < N; n++) begin
        tb_valid[n] = ($urandom_range(0, 99) < 60);
        if ($urandom_range(0, 9) == 0) tb_reg[n] = 6'(32 + $urandom_range(0, 31));
        else tb_reg[n] = 6'($urandom_range(0, 7));
        tb_data[n] = $urandom;
      end
      reset = ($urandom_range(0, 99) == 0);
      half(); edge_step();
    end
    reset = 0;
    idle();
    for (int c = 0; c < 4; c++) begin
      half(); edge_step();
    end
    half();
    chk("drain_busy", 64'(wb_busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
